// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: dispenser state encoding, coin values, BCD cent constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vm_pkg;

  // Default width of a change amount in nickel units (15 nickels = 75c).
  localparam int AMT_W_DEF = 4;

  // Coin values in nickel units.
  localparam int NICKEL = 1;
  localparam int DIME   = 2;

  // Cent/BCD constants shared with the controller's display path.
  localparam int         CENTS_PER_NICKEL = 5;
  localparam logic [3:0] BCD_UNITS_ZERO   = 4'd0;
  localparam logic [3:0] BCD_UNITS_FIVE   = 4'd5;
  localparam logic [7:0] BCD_ZERO_CENTS   = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_ACK,
    ST_DONE,
    ST_FAULT
  } disp_state_t;

  typedef enum logic {
    COIN_NICKEL,
    COIN_DIME
  } coin_t;

endpackage

// File: rtl/amt_to_bcd.sv
// Converts an amount in nickels to two-digit BCD cents for the seven-segment display.
// Latency: purely combinational.
// Backpressure: none.
// Ports: amt (nickels in), bcd (tens digit [7:4], units digit [3:0]).
module amt_to_bcd
  import vm_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic [AMT_W-1:0] amt,
  output logic [7:0]       bcd
);

  // amt*5 cents: every pair of nickels is one ten, an odd nickel leaves 5 in
  // the units digit. No divider needed. Valid for totals up to 99c, which
  // covers the 4-bit amount range (max 75c).
  logic [AMT_W-1:0] tens;

  always_comb begin
    tens = amt >> 1;
    bcd  = {4'(tens), (amt[0] ? BCD_UNITS_FIVE : BCD_UNITS_ZERO)};
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time (dimes first), confirming each coin by hopper ack.
// Latency: N coins take about N*(1+max(PULSE_CYCLES, ack_lag+1)) + 2 cycles from handshake to done.
// Backpressure: chg_ready only in IDLE; a request offered while busy is dropped, not queued.
// Ports: clk/clr_n (async active-low reset); chg_valid/chg_amt/chg_ready request handshake;
//        dime_empty/nickel_empty/hopper_ack from the hoppers; fault_clr leaves FAULT;
//        eject_dime/eject_nickel pulses; busy/done/fault status; remaining (nickels) and disp_bcd (cents).
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W        = AMT_W_DEF,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  input  logic             dime_empty,
  input  logic             nickel_empty,
  input  logic             hopper_ack,
  input  logic             fault_clr,
  output logic             eject_dime,
  output logic             eject_nickel,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [7:0]       disp_bcd
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  disp_state_t      state, state_n;
  coin_t            coin, coin_n;
  logic [AMT_W-1:0] rem_n;
  logic [PW-1:0]    pcnt, pcnt_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic             ack_lat, ack_n;
  logic             dec_en;
  logic [AMT_W-1:0] coin_val;

  assign coin_val = (coin == COIN_DIME) ? AMT_W'(DIME) : AMT_W'(NICKEL);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= ST_IDLE;
      coin         <= COIN_NICKEL;
      remaining    <= '0;
      pcnt         <= '0;
      tmr          <= '0;
      ack_lat      <= 1'b0;
      eject_dime   <= 1'b0;
      eject_nickel <= 1'b0;
    end else begin
      state        <= state_n;
      coin         <= coin_n;
      remaining    <= rem_n;
      pcnt         <= pcnt_n;
      tmr          <= tmr_n;
      ack_lat      <= ack_n;
      // Eject lines are registered from the next state so they are high for
      // exactly the cycles spent in EJECT and glitch-free at the hopper.
      eject_dime   <= (state_n == ST_EJECT) && (coin_n == COIN_DIME);
      eject_nickel <= (state_n == ST_EJECT) && (coin_n == COIN_NICKEL);
    end
  end

  always_comb begin
    state_n = state;
    coin_n  = coin;
    rem_n   = remaining;
    pcnt_n  = pcnt;
    tmr_n   = tmr;
    ack_n   = ack_lat;
    dec_en  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (chg_valid) begin
          rem_n   = chg_amt;
          state_n = ST_SELECT;
        end
      end

      // Hopper-empty flags are looked at only here; a flag that changes
      // while a coin is being ejected does not abort that coin.
      ST_SELECT: begin
        pcnt_n = '0;
        ack_n  = 1'b0;
        if (remaining == '0) begin
          state_n = ST_DONE;
        end else if ((remaining >= AMT_W'(DIME)) && !dime_empty) begin
          coin_n  = COIN_DIME;
          state_n = ST_EJECT;
        end else if (!nickel_empty) begin
          coin_n  = COIN_NICKEL;
          state_n = ST_EJECT;
        end else begin
          state_n = ST_FAULT;
        end
      end

      ST_EJECT: begin
        if (hopper_ack) begin
          ack_n = 1'b1;
        end
        if (pcnt == PW'(PULSE_CYCLES - 1)) begin
          // An ack arriving on the pulse's last cycle counts as seen during the pulse.
          if (ack_lat || hopper_ack) begin
            dec_en  = 1'b1;
            ack_n   = 1'b0;
            state_n = ST_SELECT;
          end else begin
            tmr_n   = '0;
            state_n = ST_WAIT_ACK;
          end
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end

      ST_WAIT_ACK: begin
        if (hopper_ack) begin
          dec_en  = 1'b1;
          state_n = ST_SELECT;
        end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
          // Coin not confirmed: leave remaining untouched so the display
          // shows what is still owed.
          state_n = ST_FAULT;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      ST_FAULT: begin
        if (fault_clr) begin
          rem_n   = '0;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (dec_en) begin
      rem_n = remaining - coin_val;
    end
  end

  // SELECT never picks a coin larger than what is owed, so the decrement
  // can never wrap.
  no_underflow: assert property (@(posedge clk) disable iff (!clr_n)
    dec_en |-> (remaining >= coin_val));

  assign chg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign fault     = (state == ST_FAULT);

  amt_to_bcd #(
    .AMT_W(AMT_W)
  ) u_bcd (
    .amt(remaining),
    .bcd(disp_bcd)
  );

endmodule
